// File: rtl/parking_request_frontend.sv
// -----------------------------------------------------------------------------
// parking_request_frontend
//
// Upstream stage of the parking gate controller. It cleans up the raw keypad
// strobes and the raw exit push-button and produces the request interface the
// gate controller consumes. Requests are spaced so that the controller's
// four-cycle IDLE->CHECK->OPEN->CLOSE sequence can never be overrun.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   key_valid     in   one-cycle strobe, key_data holds a digit nibble
//   key_data      in   [3:0] digit nibble
//   key_enter     in   one-cycle strobe, submit the assembled code
//   key_clear     in   one-cycle strobe, discard the assembled code
//   exit_button   in   raw asynchronous exit push-button, active-high
//   passcode_in   out  [7:0] code presented to the controller
//   enter_req     out  one-cycle entry request
//   exit_req      out  one-cycle exit request
//   digit_count   out  [1:0] nibbles currently held (0..2)
//   entry_timeout out  one-cycle pulse when a code is discarded by timeout
//   busy          out  high whenever the request FSM is not in WAIT
// -----------------------------------------------------------------------------
module parking_request_frontend #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int HOLDOFF_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       exit_button,
    output logic [7:0] passcode_in,
    output logic       enter_req,
    output logic       exit_req,
    output logic [1:0] digit_count,
    output logic       entry_timeout,
    output logic       busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_ENTRY = 2'd1,
        S_EXIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_btn_db;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_exit_pending;

    logic [7:0]      r_code;
    logic [1:0]      r_count;
    logic            r_last_entry;
    logic [HO_W-1:0] r_hold_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    logic            w_db_flip;
    logic            w_db_rise;
    logic            w_in_wait;
    logic            w_ev_clear;
    logic            w_ev_submit;
    logic            w_ev_abort;
    logic            w_ev_exit;
    logic            w_ev_digit;
    logic            w_key_accepted;
    logic            w_hold_done;
    logic            w_timeout;
    logic            w_code_clr;

    // Exit button: two-flop synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= exit_button;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing
    // samples; any agreeing sample restarts the count.
    assign w_db_flip = (r_sync2 != r_btn_db) &&
                       (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign w_db_rise = w_db_flip && !r_btn_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (w_db_flip) begin
            r_btn_db <= ~r_btn_db;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    // WAIT-state event arbitration, one event per cycle in priority order.
    assign w_in_wait      = (r_state == S_WAIT);
    assign w_ev_clear     = w_in_wait && key_clear;
    assign w_ev_submit    = w_in_wait && !key_clear && key_enter && (r_count == 2'd2);
    assign w_ev_abort     = w_in_wait && !key_clear && key_enter && (r_count != 2'd2);
    assign w_ev_exit      = w_in_wait && !key_clear && !key_enter && r_exit_pending;
    assign w_ev_digit     = w_in_wait && !key_clear && !key_enter && !r_exit_pending &&
                            key_valid && (r_count != 2'd2);
    assign w_key_accepted = w_ev_clear || w_ev_submit || w_ev_abort || w_ev_digit;

    assign w_hold_done = (r_state == S_HOLD) &&
                         (r_hold_cnt == HO_W'(HOLDOFF_CYCLES - 1));
    assign w_timeout   = w_in_wait && (r_count != 2'd0) && !w_key_accepted &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_code_clr  = w_ev_clear || w_ev_abort || w_timeout ||
                         (w_hold_done && r_last_entry);

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state. When holdoff expires with an exit already pending the
    // exit is dispatched on that same edge (as if WAIT had been passed through
    // in zero time), so consecutive requests are exactly 1+HOLDOFF_CYCLES apart.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT: begin
                if (w_ev_submit)    w_next_state = S_ENTRY;
                else if (w_ev_exit) w_next_state = S_EXIT;
            end
            S_ENTRY: w_next_state = S_HOLD;
            S_EXIT:  w_next_state = S_HOLD;
            S_HOLD: begin
                if (w_hold_done) w_next_state = r_exit_pending ? S_EXIT : S_WAIT;
            end
            default: w_next_state = S_WAIT;
        endcase
    end

    // FSM: outputs decoded from the state register.
    always_comb begin
        enter_req     = (r_state == S_ENTRY);
        exit_req      = (r_state == S_EXIT);
        busy          = (r_state != S_WAIT);
        digit_count   = r_count;
        entry_timeout = r_timeout;
        passcode_in   = 8'h00;
        if ((r_state == S_ENTRY) || ((r_state == S_HOLD) && r_last_entry))
            passcode_in = r_code;
    end

    // Exit pending: further presses merge; cleared when the exit pulse starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exit_pending <= 1'b0;
        end else if (w_next_state == S_EXIT) begin
            r_exit_pending <= 1'b0;
        end else if (w_db_rise) begin
            r_exit_pending <= 1'b1;
        end
    end

    // Code assembly and request bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code       <= 8'h00;
            r_count      <= 2'd0;
            r_last_entry <= 1'b0;
            r_hold_cnt   <= '0;
            r_to_cnt     <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_code_clr) begin
                r_code  <= 8'h00;
                r_count <= 2'd0;
            end else if (w_ev_digit) begin
                r_code  <= {r_code[3:0], key_data};
                r_count <= r_count + 2'd1;
            end

            if (r_state == S_ENTRY)     r_last_entry <= 1'b1;
            else if (r_state == S_EXIT) r_last_entry <= 1'b0;

            if ((r_state == S_HOLD) && !w_hold_done) r_hold_cnt <= r_hold_cnt + HO_W'(1);
            else                                     r_hold_cnt <= '0;

            // Idle counter only advances in WAIT; elsewhere it holds its value.
            if (w_in_wait) begin
                if ((r_count == 2'd0) || w_key_accepted || w_timeout) r_to_cnt <= '0;
                else                                                  r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            r_timeout <= w_timeout;
        end
    end

endmodule

// File: tb/tb_parking_request_frontend.sv
`timescale 1ns/1ps
module tb_parking_request_frontend;

    localparam int D = 4;
    localparam int T = 10;
    localparam int H = 3;

    localparam int K_ENTER = 0;
    localparam int K_EXIT  = 1;
    localparam int K_TO    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_data;
    logic       key_enter;
    logic       key_clear;
    logic       exit_button;
    logic [7:0] passcode_in;
    logic       enter_req;
    logic       exit_req;
    logic [1:0] digit_count;
    logic       entry_timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int mcyc   = 0;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] code;
    } exp_t;
    exp_t sb[$];

    parking_request_frontend #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_enter    (key_enter),
        .key_clear    (key_clear),
        .exit_button  (exit_button),
        .passcode_in  (passcode_in),
        .enter_req    (enter_req),
        .exit_req     (exit_req),
        .digit_count  (digit_count),
        .entry_timeout(entry_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mcyc <= mcyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp_v, exp_v, mcyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_data  = d;
        tick();
        key_valid = 1'b0;
        key_data  = 4'h0;
    endtask

    task automatic push(input int kind, input int cyc, input logic [7:0] code);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.code = code;
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (enter_req && exit_req) begin
            checks++;
            errors++;
            $display("FAIL req_overlap: enter_req and exit_req both 1 at cycle %0d", mcyc);
        end else if (enter_req || exit_req || entry_timeout) begin
            kind = enter_req ? K_ENTER : (exit_req ? K_EXIT : K_TO);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", kind, mcyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", kind, e.kind);
                chk("pulse_cycle", mcyc, e.cyc);
                chk("pulse_passcode", passcode_in, e.code);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_data    = 4'h0;
        key_enter   = 1'b0;
        key_clear   = 1'b0;
        exit_button = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_passcode", passcode_in, 0);
        chk("rst_enter", enter_req, 0);
        chk("rst_exit", exit_req, 0);
        chk("rst_digits", digit_count, 0);
        chk("rst_timeout", entry_timeout, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // F,F then enter: passcode 0xFF for ENTRY + 3 holdoff cycles
        key(4'hF);
        key(4'hF);
        chk("ff_digits", digit_count, 2);
        n = mcyc;
        push(K_ENTER, n + 1, 8'hFF);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        for (int i = 0; i < 1 + H; i++) begin
            chk("ff_passcode_hold", passcode_in, 8'hFF);
            chk("ff_busy", busy, 1);
            tick();
        end
        chk("ff_passcode_after", passcode_in, 0);
        chk("ff_digits_after", digit_count, 0);
        chk("ff_busy_after", busy, 0);

        // A,5,3 (third ignored) then enter: passcode 0xA5
        key(4'hA);
        key(4'h5);
        key(4'h3);
        chk("a5_digits", digit_count, 2);
        n = mcyc;
        push(K_ENTER, n + 1, 8'hA5);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        chk("a5_passcode", passcode_in, 8'hA5);
        repeat (H + 1) tick();
        chk("a5_digits_after", digit_count, 0);

        // Enter with one digit: no request, code discarded
        key(4'h7);
        chk("abort_digits_before", digit_count, 1);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        chk("abort_digits", digit_count, 0);
        chk("abort_busy", busy, 0);

        // Clear with two digits: no request, code discarded
        key(4'h1);
        key(4'h2);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("clear_digits", digit_count, 0);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        repeat (3) tick();
        chk("clear_busy", busy, 0);

        // Timeout: one digit then idle T cycles
        n = mcyc;
        push(K_TO, n + 1 + T, 8'h00);
        key(4'h9);
        chk("to_digits_before", digit_count, 1);
        repeat (T - 1) tick();
        chk("to_digits_mid", digit_count, 1);
        repeat (3) tick();
        chk("to_digits_after", digit_count, 0);

        // Exit button with three bounce glitches, then stable high
        for (int i = 0; i < 3; i++) begin
            exit_button = 1'b1;
            tick();
            exit_button = 1'b0;
            tick();
        end
        n = mcyc;
        push(K_EXIT, n + D + 3, 8'h00);
        exit_button = 1'b1;
        repeat (D + 8) tick();
        exit_button = 1'b0;
        repeat (D + 8) tick();
        chk("exit_busy_after", busy, 0);

        // Entry submit on the same edge the debounced exit press is registered
        n = mcyc;
        exit_button = 1'b1;
        key(4'h1);
        key(4'h2);
        repeat (3) tick();
        push(K_ENTER, n + D + 2, 8'h12);
        push(K_EXIT, n + D + 2 + 1 + H, 8'h00);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        repeat (2 * H + 4) tick();
        chk("coll_digits", digit_count, 0);
        exit_button = 1'b0;
        repeat (D + 8) tick();

        // Reset during HOLDOFF
        key(4'h3);
        key(4'h4);
        n = mcyc;
        push(K_ENTER, n + 1, 8'h34);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        tick();
        chk("hold_busy", busy, 1);
        chk("hold_passcode", passcode_in, 8'h34);
        reset = 1'b1;
        tick();
        chk("rsthold_passcode", passcode_in, 0);
        chk("rsthold_enter", enter_req, 0);
        chk("rsthold_exit", exit_req, 0);
        chk("rsthold_digits", digit_count, 0);
        chk("rsthold_timeout", entry_timeout, 0);
        chk("rsthold_busy", busy, 0);
        reset = 1'b0;
        repeat (10) tick();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
